// File: rtl/gen_arb_rr_lock_top.sv
// Packet-locking arbiter: strict-priority or round-robin selection, ownership held
// until the owner drops, finishes its packet, or exceeds the hold limit.
module gen_arb_rr_lock_top #(
  parameter int WID      = 4,
  parameter int MODE     = 1,
  parameter int MAX_HOLD = 16
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [WID-1:0]                           rqsts,
  input  logic [WID-1:0]                           lasts,
  output logic [WID-1:0]                           grnts,
  output logic                                     grnt_vld,
  output logic [((WID > 1) ? $clog2(WID) : 1)-1:0] grnt_idx,
  output logic                                     tout
);

  localparam int          IW       = (WID > 1) ? $clog2(WID) : 1;
  localparam logic [15:0] HOLD_LIM = 16'(MAX_HOLD);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   ptr;
  logic [15:0]     hold_cnt;

  logic            owner_req, owner_last;
  logic            nat_rel, tmo_rel, rel;
  logic [IW-1:0]   rel_ptr, arb_start;
  logic            win_vld;
  logic [IW-1:0]   win_idx;

  // Next index after idx, wrapping at WID-1.
  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] idx);
    return (idx == IW'(WID - 1)) ? '0 : idx + 1'b1;
  endfunction

  // First set request at or above start, wrapping; {found, index}.
  function automatic logic [IW:0] pick(input logic [WID-1:0] req, input logic [IW-1:0] start);
    logic [2*WID-1:0] dbl;
    int               pos;
    int               j;
    dbl = {req, req} >> start;
    pos = 0;
    for (int k = WID - 1; k >= 0; k--) begin
      if (dbl[k]) pos = k;
    end
    j = int'(start) + pos;
    if (j >= WID) j = j - WID;
    return {|req, IW'(j)};
  endfunction

  always_comb begin
    owner_req  = rqsts[grnt_idx];
    owner_last = lasts[grnt_idx];
    nat_rel    = (state == GRANT) && (!owner_req || owner_last);
    tmo_rel    = (state == GRANT) && (MAX_HOLD != 0) && (hold_cnt == HOLD_LIM) && !nat_rel;
    rel        = nat_rel || tmo_rel;
    rel_ptr    = (MODE == 1) ? next_idx(grnt_idx) : '0;
    arb_start  = (state == IDLE) ? ptr : rel_ptr;
    {win_vld, win_idx} = pick(rqsts, arb_start);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (win_vld) state_nxt = GRANT;
      GRANT:   if (rel && !win_vld) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  assign grnt_vld = (state == GRANT);

  // Grant, pointer and hold counter only move on a new grant or a release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grnts    <= '0;
      grnt_idx <= '0;
      ptr      <= '0;
      hold_cnt <= '0;
      tout     <= 1'b0;
    end else begin
      tout <= tmo_rel;
      if (state == IDLE || rel) begin
        if (rel) ptr <= rel_ptr;
        if (win_vld) begin
          grnts    <= WID'(1) << win_idx;
          grnt_idx <= win_idx;
          hold_cnt <= 16'd1;
        end else begin
          grnts    <= '0;
          grnt_idx <= '0;
          hold_cnt <= '0;
        end
      end else begin
        hold_cnt <= hold_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_gen_arb_rr_lock_top.sv
// Bench for gen_arb_rr_lock_top: round-robin and strict-priority instances driven
// in parallel and compared against an integer-level ownership model.
module tb_gen_arb_rr_lock_top;

  localparam int WID  = 4;
  localparam int MAXH = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] rqsts, lasts;
  logic [3:0] g1, g0;
  logic       v1, v0, t1, t0;
  logic [1:0] i1, i0;

  always #5 clk = ~clk;

  gen_arb_rr_lock_top #(.WID(WID), .MODE(1), .MAX_HOLD(MAXH)) dut1 (
    .clk(clk), .rst(rst), .rqsts(rqsts), .lasts(lasts),
    .grnts(g1), .grnt_vld(v1), .grnt_idx(i1), .tout(t1));

  gen_arb_rr_lock_top #(.WID(WID), .MODE(0), .MAX_HOLD(MAXH)) dut0 (
    .clk(clk), .rst(rst), .rqsts(rqsts), .lasts(lasts),
    .grnts(g0), .grnt_vld(v0), .grnt_idx(i0), .tout(t0));

  int checks   = 0;
  int failures = 0;

  // Model state per instance: [0] round-robin, [1] strict priority.
  int own[2];
  int ptr[2];
  int hold[2];
  bit tmo[2];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      own[m] = -1; ptr[m] = 0; hold[m] = 0; tmo[m] = 0;
    end
  endtask

  task automatic model_step(input int m, input int mode);
    int start;
    bit nat, forced;
    tmo[m] = 0;
    if (own[m] < 0) begin
      start = ptr[m];
    end else begin
      nat    = !rqsts[own[m]] || lasts[own[m]];
      forced = !nat && (MAXH != 0) && (hold[m] == MAXH);
      if (!nat && !forced) begin
        hold[m]++;
        return;
      end
      tmo[m] = forced;
      if (mode == 1) ptr[m] = (own[m] + 1) % WID;
      start = ptr[m];
    end
    own[m] = -1;
    for (int k = 0; k < WID; k++) begin
      if (own[m] < 0 && rqsts[(start + k) % WID]) own[m] = (start + k) % WID;
    end
    hold[m] = (own[m] >= 0) ? 1 : 0;
  endtask

  task automatic check_all();
    logic [31:0] e1, e0;
    e1 = (own[0] < 0) ? 32'd0 : (32'd1 << own[0]);
    e0 = (own[1] < 0) ? 32'd0 : (32'd1 << own[1]);
    chk("rr_grnts", 32'(g1), e1);
    chk("rr_vld",   32'(v1), 32'(own[0] >= 0));
    chk("rr_idx",   32'(i1), (own[0] < 0) ? 32'd0 : 32'(own[0]));
    chk("rr_tout",  32'(t1), 32'(tmo[0]));
    chk("sp_grnts", 32'(g0), e0);
    chk("sp_vld",   32'(v0), 32'(own[1] >= 0));
    chk("sp_idx",   32'(i0), (own[1] < 0) ? 32'd0 : 32'(own[1]));
    chk("sp_tout",  32'(t0), 32'(tmo[1]));
    chk("rr_onehot", 32'($countones(g1) <= 1), 32'd1);
  endtask

  // One clock: model advances on the edge, outputs compared 1ns later.
  task automatic cyc();
    @(posedge clk);
    model_step(0, 1);
    model_step(1, 0);
    #1;
    check_all();
  endtask

  // Mid-cycle reset pulse; outputs must clear before any clock edge.
  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all();
    #1 rst = 1'b0;
  endtask

  logic [3:0] rr_seq [5];

  initial begin
    rst   = 1'b1;
    rqsts = '0;
    lasts = '0;
    model_reset();
    rr_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    do_reset();

    // All requesting, single-beat packets: rotation vs fixed priority.
    rqsts = 4'b1111; lasts = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("rr_rotate", 32'(g1), 32'(rr_seq[k]));
      chk("sp_fixed",  32'(g0), 32'd1);
    end
    rqsts = 4'b1110;
    repeat (3) begin
      cyc();
      chk("sp_skip0", 32'(g0), 32'b0010);
    end

    // Multi-beat packet then zero-bubble handover.
    do_reset();
    rqsts = 4'b0011; lasts = 4'b0000;
    cyc();
    chk("pkt_first", 32'(g1), 32'b0001);
    repeat (3) begin
      cyc();
      chk("pkt_hold", 32'(g1), 32'b0001);
    end
    lasts = 4'b0001;
    cyc();
    chk("pkt_handover", 32'(g1), 32'b0010);

    // Sole requester never finishing: periodic timeout with re-grant.
    do_reset();
    rqsts = 4'b0100; lasts = 4'b0000;
    for (int k = 1; k <= 20; k++) begin
      cyc();
      chk("tmo_grant", 32'(g1), 32'b0100);
      chk("tmo_pulse", 32'(t1), 32'((k % 8 == 1) && (k > 1)));
    end

    // Owner drop hands over to the next requester and moves the pointer.
    do_reset();
    rqsts = 4'b0010; lasts = 4'b0000;
    cyc();
    chk("drop_own", 32'(g1), 32'b0010);
    rqsts = 4'b0110;
    cyc();
    rqsts = 4'b0100;
    cyc();
    chk("drop_next", 32'(g1), 32'b0100);
    chk("drop_ptr",  32'(dut1.ptr), 32'd2);

    // Reset mid-packet clears at once; first grant afterwards starts at 0.
    do_reset();
    rqsts = 4'b1000; lasts = 4'b0000;
    repeat (3) cyc();
    chk("pre_rst_own", 32'(g1), 32'b1000);
    #2 rst = 1'b1;
    #1;
    chk("async_grnts", 32'(g1), 32'd0);
    chk("async_vld",   32'(v1), 32'd0);
    chk("async_tout",  32'(t1), 32'd0);
    model_reset();
    rqsts = 4'b1001;
    #1 rst = 1'b0;
    cyc();
    chk("post_rst_grant", 32'(g1), 32'b0001);

    // Randomized traffic with sticky requests, sparse lasts and rare resets.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 3) == 0) rqsts = 4'($urandom);
      lasts = 4'($urandom & $urandom & $urandom);
      if ($urandom_range(0, 149) == 0) do_reset();
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gen_arb_rr_lock_top.md
GEN_ARB_RR_LOCK_TOP -- requirements
Module: gen_arb_rr_lock_top

Interface
REQ-001 Parameter WID, default 4: number of requesters; legal range 2..32.
REQ-002 Parameter MODE, default 1: 0 = strict priority with lsb highest; 1 = round-robin.
REQ-003 Parameter MAX_HOLD, default 16: maximum granted cycles per ownership; 0 disables the timeout; otherwise legal range 2..65535.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 rqsts  input  WID  request bus; bit i high means requester i wants the resource or presents a beat.
REQ-007 lasts  input  WID  bit i high marks the current beat of requester i as the final beat of its packet.
REQ-008 grnts  output  WID  registered grant bus; one-hot or zero.
REQ-009 grnt_vld  output  1  registered; high exactly when grnts is non-zero.
REQ-010 grnt_idx  output  max(1,$clog2(WID))  registered binary index of the owner; 0 when no grant is active.
REQ-011 tout  output  1  registered one-cycle pulse indicating a forced release by timeout.

Function
REQ-012 The FSM SHALL have two states: IDLE (no owner) and GRANT (owner locked); grnt_vld SHALL equal (state==GRANT).
REQ-013 Winner selection SHALL be combinational over the candidate vector, scanning upward with wrap from start index ptr; MODE=0 SHALL force ptr=0.
REQ-014 IDLE: if rqsts!=0, the winner SHALL be registered into grnts/grnt_idx and the FSM SHALL enter GRANT; latency is 1 cycle from rqsts to grnts.
REQ-015 GRANT: a beat is any cycle in which rqsts[grnt_idx]=1.
REQ-016 Natural release SHALL occur in a cycle where either rqsts[grnt_idx]=0 (drop), or a beat occurs with lasts[grnt_idx]=1.
REQ-017 On release in MODE=1, ptr SHALL be updated to (grnt_idx+1) mod WID, wrapping from WID-1 to 0.
REQ-018 On release, re-arbitration over the full current rqsts using the updated ptr SHALL occur in the same cycle (zero-bubble handover).
    - Non-zero result: the next owner is registered directly; the FSM stays in GRANT.
    - Zero result: next cycle is IDLE with grnts=0.
REQ-019 The releasing owner MAY win re-arbitration; in MODE=1 it SHALL win only when no other requester is high.
REQ-020 While no release occurs, grnts, grnt_idx and ptr SHALL remain stable regardless of other rqsts or lasts bits.
REQ-021 lasts bits of non-owners, and lasts bits while in IDLE, SHALL be ignored.
REQ-022 hold_cnt (16 bits) SHALL load 1 on every new grant and SHALL increment each cycle in GRANT without release.
REQ-023 Forced release SHALL occur when MAX_HOLD!=0, hold_cnt==MAX_HOLD, and no natural release happens in that cycle.
    - Same effects as a natural release: ptr advances and re-arbitration runs.
    - tout SHALL be 1 in the following cycle only.
REQ-024 When a natural release and the timeout coincide, the release SHALL be treated as natural and tout SHALL stay 0.
REQ-025 grnts SHALL never have more than one bit set, and SHALL never be set for a requester whose rqsts bit was low at the arbitration edge.

Reset
REQ-026 While rst=1, the following SHALL hold asynchronously:
    - grnts=0, grnt_vld=0, grnt_idx=0, tout=0;
    - ptr=0, hold_cnt=0, state=IDLE.
REQ-027 Reset asserted mid-packet SHALL drop the grant immediately with no tout pulse.
REQ-028 The first arbitration after rst deasserts SHALL use ptr=0.

Verification (WID=4, MAX_HOLD=8 unless stated)
REQ-029 MODE=1, rqsts=1111 and lasts=1111 held -> grnts sequence 0000, 0001, 0010, 0100, 1000, 0001 on consecutive cycles; tout stays 0.
REQ-030 MODE=1, rqsts=0011, lasts=0000 for the first 3 owner beats, then lasts=0001 -> grnts=0001 for 4 cycles, then 0010 with no bubble cycle.
REQ-031 MODE=0, rqsts=1111 and lasts=1111 held -> grnts=0001 every cycle after the first; with rqsts=1110 -> 0010 every cycle.
REQ-032 MODE=1, rqsts=0100 and lasts=0000 held -> grnts=0100 for exactly 8 cycles, tout=1 on the 9th cycle, re-grant 0100 on the 9th cycle (sole requester), and the pattern repeats.
REQ-033 Owner drop: grnts=0010, then rqsts goes 0110 -> 0100 in cycle t -> grnts=0100 at t+1 and ptr=2.
REQ-034 rst pulsed while grnts=1000 mid-packet -> grnts=0 and grnt_vld=0 without waiting for a clock edge; after release with rqsts=1001, first grant is 0001.
